// File: rtl/vga_pkg.sv
// Shared constants for the VGA compositing pipeline: default pixel format,
// default background/key colours and layer-slice helpers.
package vga_pkg;

    localparam int          COLOR_W_DEF   = 16;
    localparam logic [15:0] BG_COLOR_DEF  = 16'h0000;
    localparam logic [15:0] KEY_COLOR_DEF = 16'hF81F;
    localparam int          MAX_LAYERS    = 8;
    localparam int          LAYER_IDX_W   = 3;
    localparam int          SYNC_W        = 4;

    // Low bit of layer idx inside a packed bus of width-wide slices.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Generic DEPTH x WIDTH shift register with synchronous active-high clear;
// DEPTH = 0 degenerates to a wire.
module vga_sync_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_data = i_data;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Shift stages forward each cycle, clearing all of them on reset.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_stage[k] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_stage[k] <= r_stage[k-1];
                    end
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_compositor.sv
// Priority layer compositor: aligns scan syncs with layer data, picks the
// highest opaque layer, registers colour and syncs. Option: VGA_COMP_CHROMA_KEY_EN.
module vga_compositor
    import vga_pkg::*;
#(
    parameter int                 LAYERS    = 4,
    parameter int                 COLOR_W   = COLOR_W_DEF,
    parameter int                 SRC_LAT   = 1,
    parameter logic [COLOR_W-1:0] BG_COLOR  = COLOR_W'(BG_COLOR_DEF),
    parameter logic [COLOR_W-1:0] KEY_COLOR = COLOR_W'(KEY_COLOR_DEF)
) (
    input  logic                      pix_clk,
    input  logic                      pix_rst,
    input  logic                      in_hsync,
    input  logic                      in_vsync,
    input  logic                      in_de,
    input  logic                      in_frame,
    input  logic [LAYERS*COLOR_W-1:0] layer_color,
    input  logic [LAYERS-1:0]         layer_valid,
    input  logic [LAYERS-1:0]         layer_en,
    output logic                      vga_hsync,
    output logic                      vga_vsync,
    output logic                      vga_de,
    output logic [COLOR_W-1:0]        vga_rgb,
    output logic [15:0]               frame_cnt
);

    generate
        if (LAYERS < 1 || LAYERS > MAX_LAYERS) begin : g_bad_layers
            $error("vga_compositor: LAYERS out of range");
        end
        if (SRC_LAT < 0 || SRC_LAT > 4) begin : g_bad_lat
            $error("vga_compositor: SRC_LAT out of range");
        end
        if ($bits(KEY_COLOR) != COLOR_W) begin : g_bad_key
            $error("vga_compositor: KEY_COLOR width mismatch");
        end
    endgenerate

    logic [SYNC_W-1:0]  w_sync_al;
    logic               w_hs_a;
    logic               w_vs_a;
    logic               w_de_a;
    logic               w_fr_a;
    logic [LAYERS-1:0]  r_mask;
    logic [LAYERS-1:0]  w_mask;
    logic [LAYERS-1:0]  w_key_ok;
    logic [LAYERS-1:0]  w_opaque;
    logic [COLOR_W-1:0] w_pix;

    vga_sync_delay #(
        .DEPTH (SRC_LAT),
        .WIDTH (SYNC_W)
    ) u_sync_delay (
        .i_clk  (pix_clk),
        .i_rst  (pix_rst),
        .i_data ({in_frame, in_de, in_vsync, in_hsync}),
        .o_data (w_sync_al)
    );

    assign {w_fr_a, w_de_a, w_vs_a, w_hs_a} = w_sync_al;

    // A mask loaded on the strobe cycle already governs that cycle's pixel.
    assign w_mask = w_fr_a ? layer_en : r_mask;

    generate
        for (genvar g = 0; g < LAYERS; g++) begin : g_layer
`ifdef VGA_COMP_CHROMA_KEY_EN
            assign w_key_ok[g] = (layer_color[slice_lo(g, COLOR_W) +: COLOR_W] != KEY_COLOR);
`else
            assign w_key_ok[g] = 1'b1;
`endif
            assign w_opaque[g] = layer_valid[g] & w_mask[g] & w_key_ok[g];
        end
    endgenerate

    // Later (higher-index) opaque layers overwrite earlier ones.
    always_comb begin
        w_pix = BG_COLOR;
        for (int i = 0; i < LAYERS; i++) begin
            w_pix = w_opaque[i] ? layer_color[slice_lo(i, COLOR_W) +: COLOR_W] : w_pix;
        end
    end

    // Output stage: syncs, blanked colour, frame counter and shadow mask.
    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            vga_hsync <= 1'b0;
            vga_vsync <= 1'b0;
            vga_de    <= 1'b0;
            vga_rgb   <= '0;
            frame_cnt <= 16'd0;
            r_mask    <= '1;
        end else begin
            vga_hsync <= w_hs_a;
            vga_vsync <= w_vs_a;
            vga_de    <= w_de_a;
            vga_rgb   <= w_de_a ? w_pix : '0;
            frame_cnt <= frame_cnt + {15'd0, w_fr_a};
            r_mask    <= w_mask;
        end
    end

endmodule

// File: tb/tb_vga_compositor.sv
// Scoreboard bench for vga_compositor (LAYERS=4, COLOR_W=16, SRC_LAT=1).
module tb_vga_compositor;

    logic        pix_clk     = 1'b0;
    logic        pix_rst     = 1'b1;
    logic        in_hsync    = 1'b0;
    logic        in_vsync    = 1'b0;
    logic        in_de       = 1'b0;
    logic        in_frame    = 1'b0;
    logic [63:0] layer_color = 64'd0;
    logic [3:0]  layer_valid = 4'd0;
    logic [3:0]  layer_en    = 4'hF;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_de;
    logic [15:0] vga_rgb;
    logic [15:0] frame_cnt;

    vga_compositor #(
        .LAYERS  (4),
        .COLOR_W (16),
        .SRC_LAT (1)
    ) dut (
        .pix_clk     (pix_clk),
        .pix_rst     (pix_rst),
        .in_hsync    (in_hsync),
        .in_vsync    (in_vsync),
        .in_de       (in_de),
        .in_frame    (in_frame),
        .layer_color (layer_color),
        .layer_valid (layer_valid),
        .layer_en    (layer_en),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_de      (vga_de),
        .vga_rgb     (vga_rgb),
        .frame_cnt   (frame_cnt)
    );

    always #5 pix_clk = ~pix_clk;

    int cyc = 0;
    always @(posedge pix_clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        hs;
        logic        vs;
        logic        de;
        logic [15:0] rgb;
        logic [15:0] fc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_fc  = 16'd0;
    logic [63:0] p_col = 64'd0;
    logic [3:0]  p_val = 4'd0;
    logic [3:0]  p_en  = 4'hF;

`ifdef VGA_COMP_CHROMA_KEY_EN
    localparam logic [15:0] KEY_EXP = 16'h07E0;
`else
    localparam logic [15:0] KEY_EXP = 16'hF81F;
`endif

    localparam logic [63:0] COL_PRI  = {16'hF800, 16'h0000, 16'h0000, 16'h001F};
    localparam logic [63:0] COL_KEY  = {16'hF81F, 16'h0000, 16'h07E0, 16'h0000};
    localparam logic [63:0] COL_FULL = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    // Syncs go out now; layer data of the same pixel follows one cycle later.
    task automatic step(input logic rst, input logic hs, input logic vs, input logic de,
                        input logic fr, input logic [3:0] en, input logic [3:0] val,
                        input logic [63:0] col, input logic [15:0] exp_rgb);
        exp_t x;
        @(negedge pix_clk);
        pix_rst     = rst;
        in_hsync    = hs;
        in_vsync    = vs;
        in_de       = de;
        in_frame    = fr;
        layer_color = p_col;
        layer_valid = p_val;
        layer_en    = p_en;
        p_col       = col;
        p_val       = val;
        p_en        = en;
        x.due       = cyc + 2;
        if (rst) begin
            foreach (sb[k]) begin
                if (sb[k].due >= cyc + 1) begin
                    sb[k].hs  = 1'b0;
                    sb[k].vs  = 1'b0;
                    sb[k].de  = 1'b0;
                    sb[k].rgb = 16'h0000;
                    sb[k].fc  = 16'h0000;
                end
            end
            m_fc  = 16'd0;
            x.hs  = 1'b0;
            x.vs  = 1'b0;
            x.de  = 1'b0;
            x.rgb = 16'h0000;
            x.fc  = 16'h0000;
        end else begin
            if (fr) m_fc = m_fc + 16'd1;
            x.hs  = hs;
            x.vs  = vs;
            x.de  = de;
            x.rgb = exp_rgb;
            x.fc  = m_fc;
        end
        sb.push_back(x);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 64'd0, 16'h0000);
    endtask

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge pix_clk) begin
        exp_t x;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            x = sb.pop_front();
            if (x.due < cyc) begin
                chk("stale_entry", 16'(cyc), 16'(x.due));
            end else begin
                chk("vga_hsync", {15'd0, vga_hsync}, {15'd0, x.hs});
                chk("vga_vsync", {15'd0, vga_vsync}, {15'd0, x.vs});
                chk("vga_de",    {15'd0, vga_de},    {15'd0, x.de});
                chk("vga_rgb",   vga_rgb,            x.rgb);
                chk("frame_cnt", frame_cnt,          x.fc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 64'd0, 16'h0000);
        while (cyc < 9) idle();
        // Lone de pulse at cycle 10, no layer valid: background at cycle 12.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 64'd0, 16'h0000);
        repeat (3) idle();

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 64'd0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'b1001, COL_PRI, 16'hF800);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'b0001, COL_PRI, 16'h001F);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'b0000, COL_PRI, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'b1010, COL_KEY, KEY_EXP);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'b1111, COL_FULL, 16'h0000);

        // Mid-frame enable change is ignored until the next strobe.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0111, 4'b1001, COL_PRI, 16'hF800);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0111, 4'b1001, COL_PRI, 16'h001F);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b1001, COL_PRI, 16'h001F);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1001, COL_PRI, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 4'b1001, COL_PRI, 16'hF800);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, COL_PRI, 16'h0000);

        // Reset in the middle of an active line, then mask back to all ones.
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'b0001, COL_PRI, 16'h001F);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'b0001, COL_PRI, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'b1000, COL_PRI, 16'hF800);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'b1001, COL_PRI, 16'hF800);
        repeat (2) idle();

        // 65536 back-to-back strobes bring the counter round to zero.
        repeat (65536) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 64'd0, 16'h0000);
        repeat (2) idle();

        repeat (3) @(negedge pix_clk);
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_compositor.md
VGA_COMPOSITOR -- requirements
Module: vga_compositor

Interface
REQ-001 The block SHALL have parameter LAYERS, default 4, giving the number of colour layers, range 1..8.
REQ-002 The block SHALL have parameter COLOR_W, default 16, giving the pixel width (RGB565 at 16).
REQ-003 The block SHALL have parameter SRC_LAT, default 1, giving the cycle latency of the layer sources relative to the scan signals, range 0..4.
REQ-004 The block SHALL have parameter BG_COLOR, default 0, giving the colour used when no layer is opaque.
REQ-005 The block SHALL have parameter KEY_COLOR, default 16'hF81F, giving the transparent chroma key.
REQ-006 The block SHALL have port pix_clk, input, 1 bit: the pixel clock, the only clock.
REQ-007 The block SHALL have port pix_rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port in_hsync, input, 1 bit: raw horizontal sync from the scanner.
REQ-009 The block SHALL have port in_vsync, input, 1 bit: raw vertical sync from the scanner.
REQ-010 The block SHALL have port in_de, input, 1 bit: raw data enable from the scanner.
REQ-011 The block SHALL have port in_frame, input, 1 bit: one-cycle new-frame strobe from the scanner.
REQ-012 The block SHALL have port layer_color, input, LAYERS*COLOR_W bits: layer i occupies bits [i*COLOR_W +: COLOR_W].
REQ-013 The block SHALL have port layer_valid, input, LAYERS bits: per-pixel opaque flag for each layer.
REQ-014 The block SHALL have port layer_en, input, LAYERS bits: requested layer enable mask, frame-synchronous.
REQ-015 The block SHALL have outputs vga_hsync, vga_vsync and vga_de, each 1 bit: registered, aligned syncs.
REQ-016 The block SHALL have output vga_rgb, COLOR_W bits: registered composited colour.
REQ-017 The block SHALL have output frame_cnt, 16 bits: count of frames composited.

Function
REQ-018 The block SHALL delay in_hsync, in_vsync, in_de and in_frame through a SRC_LAT-deep shift register, so they align with layer_color and layer_valid; at SRC_LAT=0 these signals pass directly.
REQ-019 The block SHALL treat layer i as opaque when layer_valid[i], the active-mask bit i and the key condition (REQ-033) are all true.
REQ-020 The block SHALL have the highest-index opaque layer win; when no layer is opaque, the result SHALL be BG_COLOR.
REQ-021 The block SHALL register the composite result and the aligned syncs together in one output stage.
REQ-022 The total in_* to vga_* latency SHALL be SRC_LAT+1 cycles.
REQ-023 The block SHALL drive vga_rgb to 0 in every cycle where the aligned de is 0, regardless of layer inputs.
REQ-024 The block SHALL hold the active mask in a shadow register and load it from layer_en only in the cycle the aligned in_frame is 1; mid-frame changes to layer_en SHALL have no effect.
REQ-025 A mask loaded at a frame strobe SHALL apply to that same cycle's pixel.
REQ-026 The block SHALL increment frame_cnt by 1 on each aligned in_frame, wrapping from 16'hFFFF to 0.
REQ-027 If in_frame is asserted on consecutive cycles, each cycle SHALL count and load the mask.
REQ-028 Layer inputs outside the aligned de SHALL be ignored.

Reset
REQ-029 When pix_rst is 1 at a pix_clk edge, the block SHALL clear all delay-line stages to 0.
REQ-030 Under reset, vga_hsync, vga_vsync, vga_de, vga_rgb and frame_cnt SHALL all be 0.
REQ-031 Under reset, the active mask SHALL become all ones.
REQ-032 When reset is asserted mid-line, outputs SHALL be 0 from the next edge; after release, the first SRC_LAT+1 output cycles SHALL carry the flushed zeros before live data.

Configuration
REQ-033 With macro VGA_COMP_CHROMA_KEY_EN defined, a layer whose colour equals KEY_COLOR SHALL be transparent even when its valid bit is set; without the macro, no colour comparison logic SHALL exist and only layer_valid and the mask decide opacity.

Structure
REQ-034 COLOR_W default, the BG_COLOR and KEY_COLOR defaults, and the layer-slice helper width constants SHALL live in the shared package vga_pkg.
REQ-035 The delay line SHALL be the sub-module vga_sync_delay, parameterised by depth and width, and shared with other pipelines.

Verification
REQ-036 The bench SHALL check latency: with SRC_LAT=1 and an in_de pulse at cycle 10, vga_de SHALL be 1 at cycle 12 and at no other cycle.
REQ-037 The bench SHALL check priority: with layer 0 valid 16'h001F and layer 3 valid 16'hF800 during de, vga_rgb SHALL be 16'hF800; with no layer valid, vga_rgb SHALL be BG_COLOR.
REQ-038 The bench SHALL check chroma key: with the macro defined, layer 3 valid and 16'hF81F, and layer 1 valid 16'h07E0, vga_rgb SHALL be 16'h07E0; without the macro, vga_rgb SHALL be 16'hF81F.
REQ-039 The bench SHALL check the mask: layer_en set to 4'b0111 mid-frame SHALL leave layer 3 still visible; after the next in_frame, layer 3 SHALL be suppressed.
REQ-040 The bench SHALL check the blank level: with de low and all layers valid 16'hFFFF, vga_rgb SHALL be 0.
REQ-041 The bench SHALL check reset and wrap: frame_cnt forced through 65536 strobes SHALL read 0; pix_rst mid-line SHALL clear all outputs on the next edge and restore the mask to 4'b1111.
